sam_spi_reg_slave: RTL
======================

Name: sam_spi_reg_slave

Overview:
- SPI mode-0 responder (slave) for the SAM D21 host link on the MKR header pins.
- Turns host SPI frames into single-cycle register read/write strobes toward the FPGA register bank in the iCLK domain.
- SCK, CSn and MOSI are oversampled by iCLK; the block has no SCK clock domain.
- Frame = 1 command byte (bit7 = 1 read / 0 write, bits6:0 = start address), then any number of data bytes with address auto-increment.

Parameters:
- ADDR_W, 7, register address width; must be ≤7 because it is taken from command bits6:0.
- SYNC_STAGES, 2, synchroniser depth on SCK, CSn and MOSI; minimum 2.

Ports:
- iCLK  in  1  system clock; fSCK ≤ fiCLK/8.
- iRESETn  in  1  asynchronous active-low reset.
- iSPI_SCK  in  1  host SPI clock, mode 0 (CPOL=0, CPHA=0).
- iSPI_CSn  in  1  host chip select, active low.
- iSPI_MOSI  in  1  host data in, MSB first.
- oSPI_MISO  out  1  data to host, MSB first.
- oSPI_MISO_OE  out  1  MISO pad drive enable.
- oREG_ADDR  out  ADDR_W  register address.
- oREG_WR  out  1  one-cycle write strobe.
- oREG_WDATA  out  8  write data, valid with oREG_WR.
- oREG_RD  out  1  one-cycle read request.
- iREG_RDATA  in  8  read data, valid 1 iCLK after oREG_RD.
- oBUSY  out  1  high while a frame is open.
- oFRAME_DONE  out  1  one-cycle pulse at end of a valid frame.

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to SCK=0, CSn=1, MOSI=0. State = IDLE; bit counter, shift registers and address = 0.
- Edge detect runs on the synchronised signals. sck_rise = MOSI sample point; sck_fall = MISO update point.
- oSPI_MISO_OE = !CSn_sync, registered.
- IDLE: wait for a CSn_sync falling edge, then go to CMD and set oBUSY=1. A low CSn already present when reset releases is ignored until CSn has been seen high.
- CMD: shift MOSI in on each sck_rise; oSPI_MISO holds 0.
  - On the 8th rise, latch the address from bits6:0 and the read/write flag from bit7, then go to DATA.
  - If read: assert oREG_RD for 1 cycle, with oREG_ADDR = start address, in the cycle after the 8th rise. Capture iREG_RDATA into the TX shift register on the next cycle.
- DATA, write: on the 8th rise of each byte, assert oREG_WR for 1 cycle with oREG_ADDR/oREG_WDATA. Increment the address on the following cycle.
- DATA, read:
  - On each sck_fall, drive the next TX bit on oSPI_MISO; bit7 goes out on the fall that follows the command byte's 8th rise.
  - On the 8th rise of each data byte, increment the address, then assert oREG_RD to prefetch the next byte in time for the next fall.
- Address arithmetic is modulo 2^ADDR_W: 127 wraps to 0, with no error.
- CSn_sync rising edge, from any state:
  - Return to IDLE and clear oBUSY.
  - Discard any partial byte; no strobe is issued for it.
  - oSPI_MISO goes to 0.
  - Pulse oFRAME_DONE for 1 cycle if the command byte completed; otherwise no pulse.
- Priority: an SCK edge in the same cycle as the CSn rise is ignored (CSn wins). SCK edges while CSn_sync is high are ignored.
- Asynchronous reset mid-frame: immediate return to reset values; no strobe is emitted.
- Latency: strobes are issued ≤SYNC_STAGES+2 iCLK after the physical 8th SCK rise.

Test Plan:
- Write frame, CSn low, bytes 0x05, 0xA1, 0xB2, CSn high -> oREG_WR pulses at addr 0x05 data 0xA1, then addr 0x06 data 0xB2; then one oFRAME_DONE pulse.
- Read frame 0x83 then two dummy bytes, bank returns addr+0x10 -> oREG_RD at 0x03 and 0x04 (0x05 prefetch allowed); MISO bytes 0x13, 0x14; MISO=0 during the command byte.
- Wrap: write command 0x7F, data 0x11, 0x22 -> writes at 0x7F, then 0x00.
- Abort: CSn rises after 5 bits of the second data byte in a write -> exactly one oREG_WR; oFRAME_DONE pulses. CSn rises mid-command -> no strobes, no oFRAME_DONE.
- Reset: assert iRESETn low mid read frame -> all outputs 0 immediately. A release with CSn still low gives no strobes until CSn goes high then low; a fresh 0x01/0x55 frame then writes correctly.
- Speed limit: SCK = iCLK/8 with random inter-byte gaps, 64-byte write burst -> 64 strobes, addresses contiguous, data matches.

Source files
------------

// File: rtl/sam_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : sam_spi_reg_slave
// Description : SPI mode-0 responder, iCLK-oversampled, mapping host frames
//               onto single-cycle register read/write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sam_spi_reg_slave #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iSPI_SCK,
    input  logic              iSPI_CSn,
    input  logic              iSPI_MOSI,
    output logic              oSPI_MISO,
    output logic              oSPI_MISO_OE,
    output logic [ADDR_W-1:0] oREG_ADDR,
    output logic              oREG_WR,
    output logic [7:0]        oREG_WDATA,
    output logic              oREG_RD,
    input  logic [7:0]        iREG_RDATA,
    output logic              oBUSY,
    output logic              oFRAME_DONE
);

    localparam logic [1:0]        c_st_idle  = 2'd0;
    localparam logic [1:0]        c_st_cmd   = 2'd1;
    localparam logic [1:0]        c_st_data  = 2'd2;
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q, vld_q;
    logic                   sck_prev_q, csn_prev_q;
    logic                   armed_q, armed_d;
    logic [1:0]             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rd_flag_q, rd_flag_d;
    logic                   miso_q, miso_d;
    logic                   oe_q;
    logic                   wr_q, wr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   rd_q, rd_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   inc_q, inc_d;
    logic                   cap_q;

    logic       w_sck, w_csn, w_mosi, w_vld;
    logic       w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall;
    logic [7:0] w_rx_byte;

    assign w_sck      = sck_sync_q[SYNC_STAGES-1];
    assign w_csn      = csn_sync_q[SYNC_STAGES-1];
    assign w_mosi     = mosi_sync_q[SYNC_STAGES-1];
    assign w_vld      = vld_q[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~sck_prev_q;
    assign w_sck_fall = ~w_sck & sck_prev_q;
    assign w_csn_rise = w_csn & ~csn_prev_q;
    assign w_csn_fall = ~w_csn & csn_prev_q;
    assign w_rx_byte  = {rx_q[6:0], w_mosi};

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], iSPI_SCK};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], iSPI_CSn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], iSPI_MOSI};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= w_sck;
            csn_prev_q  <= w_csn;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rd_flag_d = rd_flag_q;
        miso_d    = miso_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        done_d    = 1'b0;
        inc_d     = 1'b0;
        // The synchroniser reset value of CSn is not a real sample, so only a
        // genuinely observed high level arms frame detection.
        armed_d   = armed_q | (w_vld & w_csn);

        if (inc_q) addr_d = addr_q + c_addr_one;
        if (cap_q) tx_d = iREG_RDATA;

        if (w_csn_rise) begin
            state_d   = c_st_idle;
            busy_d    = 1'b0;
            miso_d    = 1'b0;
            bit_cnt_d = 3'd0;
            rx_d      = 8'd0;
            done_d    = (state_q == c_st_data);
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (armed_q && w_csn_fall) begin
                        state_d   = c_st_cmd;
                        busy_d    = 1'b1;
                        bit_cnt_d = 3'd0;
                        rx_d      = 8'd0;
                        miso_d    = 1'b0;
                    end
                end
                c_st_cmd: begin
                    if (w_sck_rise) begin
                        rx_d      = w_rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d    = w_rx_byte[ADDR_W-1:0];
                            rd_flag_d = w_rx_byte[7];
                            rd_d      = w_rx_byte[7];
                            state_d   = c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (w_sck_rise) begin
                        rx_d      = w_rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rd_flag_q) begin
                                addr_d = addr_q + c_addr_one;
                                rd_d   = 1'b1;
                            end else begin
                                wr_d    = 1'b1;
                                wdata_d = w_rx_byte;
                                inc_d   = 1'b1;
                            end
                        end
                    end
                    if (w_sck_fall && rd_flag_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                default: state_d = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            armed_q   <= 1'b0;
            state_q   <= c_st_idle;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'd0;
            tx_q      <= 8'd0;
            addr_q    <= '0;
            rd_flag_q <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 8'd0;
            rd_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            inc_q     <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            rd_flag_q <= rd_flag_d;
            miso_q    <= miso_d;
            oe_q      <= ~w_csn;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            inc_q     <= inc_d;
            cap_q     <= rd_q;
        end
    end

    assign oSPI_MISO    = miso_q;
    assign oSPI_MISO_OE = oe_q;
    assign oREG_ADDR    = addr_q;
    assign oREG_WR      = wr_q;
    assign oREG_WDATA   = wdata_q;
    assign oREG_RD      = rd_q;
    assign oBUSY        = busy_q;
    assign oFRAME_DONE  = done_q;

endmodule
`default_nettype wire
